// File: rtl/oven_controller.sv
// oven_controller
// Control-side producer for the oven seven-segment display. Turns debounced
// front-panel keys into target temperature/time, sequences the oven through
// set-temperature, set-time, preheat, cook and done, models the oven
// temperature with a bang-bang heater and counts cook time down once per
// second.

module oven_controller #(
    parameter int CLKS_PER_SEC = 50000000,
    parameter int TEMP_MIN     = 100,
    parameter int TEMP_MAX     = 500,
    parameter int TEMP_STEP    = 25,
    parameter int TEMP_DEFAULT = 350,
    parameter int AMBIENT      = 70,
    parameter int HEAT_RATE    = 5,
    parameter int COOL_RATE    = 2,
    parameter int TIME_STEP    = 10,
    parameter int TIME_MAX     = 3599
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power_sw,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_enter,
    output logic        power,
    output logic        tempInputDone,
    output logic        timeInputDone,
    output logic [9:0]  current_temp,
    output logic [9:0]  target_temp,
    output logic [12:0] current_time,
    output logic [12:0] target_time,
    output logic        heater_on,
    output logic        done_beep
);

    typedef enum logic [2:0] {
        S_OFF,
        S_SET_TEMP,
        S_SET_TIME,
        S_PREHEAT,
        S_COOK,
        S_DONE
    } state_t;

    // Prescaler width; a one-cycle second still needs a 1-bit counter.
    localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_SEC - 1);

    // Temperature arithmetic is carried one bit wider than the outputs so
    // that a sum above 999 or a difference below zero is visible before the
    // saturation compare.
    localparam logic [10:0] TEMP_CEIL = 11'd999;
    localparam logic [10:0] T_MIN_W   = 11'(TEMP_MIN);
    localparam logic [10:0] T_MAX_W   = 11'(TEMP_MAX);
    localparam logic [10:0] T_STEP_W  = 11'(TEMP_STEP);
    localparam logic [10:0] AMB_W     = 11'(AMBIENT);
    localparam logic [10:0] HEAT_W    = 11'(HEAT_RATE);
    localparam logic [10:0] COOL_W    = 11'(COOL_RATE);
    localparam logic [9:0]  T_DEF     = 10'(TEMP_DEFAULT);
    localparam logic [9:0]  AMB       = 10'(AMBIENT);

    // Time arithmetic likewise carries one guard bit.
    localparam logic [13:0] M_STEP_W = 14'(TIME_STEP);
    localparam logic [13:0] M_MAX_W  = 14'(TIME_MAX);

    state_t         state;
    logic [PW-1:0]  prescale;
    logic           tick;

    logic           up_q;
    logic           down_q;
    logic           enter_q;
    logic           up_edge;
    logic           down_edge;
    logic           enter_p;
    logic           up_p;
    logic           down_p;

    logic [10:0]    temp_wide;
    logic [10:0]    temp_sum;
    logic [9:0]     temp_heated;
    logic [9:0]     temp_cooled;

    logic [10:0]    tgt_wide;
    logic [10:0]    tgt_sum;
    logic [9:0]     tgt_up;
    logic [9:0]     tgt_down;

    logic [13:0]    tim_wide;
    logic [13:0]    tim_sum;
    logic [12:0]    tim_up;
    logic [12:0]    tim_down;

    logic           below_target;

    // ------------------------------------------------------------------
    // Key edge detection. Enter dominates; up+down together cancel.
    // ------------------------------------------------------------------

    // Remember last sampled key levels so a held key acts only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            up_q    <= key_up;
            down_q  <= key_down;
            enter_q <= key_enter;
        end
    end

    assign up_edge   = key_up    & ~up_q;
    assign down_edge = key_down  & ~down_q;
    assign enter_p   = key_enter & ~enter_q;
    assign up_p      = up_edge   & ~down_edge & ~enter_p;
    assign down_p    = down_edge & ~up_edge   & ~enter_p;

    // ------------------------------------------------------------------
    // One-second tick: free-running prescaler, cleared only by reset.
    // ------------------------------------------------------------------

    // Count 0..CLKS_PER_SEC-1 and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
        end else if (prescale == PRE_LAST) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    assign tick = (prescale == PRE_LAST);

    // ------------------------------------------------------------------
    // Saturating arithmetic for temperature model and settings.
    // ------------------------------------------------------------------

    assign temp_wide   = {1'b0, current_temp};
    assign temp_sum    = temp_wide + HEAT_W;
    assign temp_heated = 10'((temp_sum > TEMP_CEIL) ? TEMP_CEIL : temp_sum);
    assign temp_cooled = 10'((temp_wide < AMB_W + COOL_W) ? AMB_W : temp_wide - COOL_W);

    assign tgt_wide = {1'b0, target_temp};
    assign tgt_sum  = tgt_wide + T_STEP_W;
    assign tgt_up   = 10'((tgt_sum > T_MAX_W) ? T_MAX_W : tgt_sum);
    assign tgt_down = 10'((tgt_wide < T_MIN_W + T_STEP_W) ? T_MIN_W : tgt_wide - T_STEP_W);

    assign tim_wide = {1'b0, target_time};
    assign tim_sum  = tim_wide + M_STEP_W;
    assign tim_up   = 13'((tim_sum > M_MAX_W) ? M_MAX_W : tim_sum);
    assign tim_down = 13'((tim_wide < M_STEP_W) ? 14'd0 : tim_wide - M_STEP_W);

    assign below_target = (current_temp < target_temp);

    // ------------------------------------------------------------------
    // Oven temperature model: one heat or cool step per tick, any state.
    // ------------------------------------------------------------------

    // Integrate heater command once per second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_temp <= AMB;
        end else if (tick) begin
            current_temp <= heater_on ? temp_heated : temp_cooled;
        end
    end

    // ------------------------------------------------------------------
    // Operating sequence with registered display/heater outputs.
    // ------------------------------------------------------------------

    // Sequence OFF -> SET_TEMP -> SET_TIME -> PREHEAT -> COOK -> DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_OFF;
            power         <= 1'b0;
            tempInputDone <= 1'b0;
            timeInputDone <= 1'b0;
            target_temp   <= T_DEF;
            target_time   <= '0;
            current_time  <= '0;
            heater_on     <= 1'b0;
            done_beep     <= 1'b0;
        end else if (!power_sw) begin
            // Power switch off overrides keys and ticks from any state.
            state         <= S_OFF;
            power         <= 1'b0;
            tempInputDone <= 1'b0;
            timeInputDone <= 1'b0;
            target_temp   <= T_DEF;
            target_time   <= '0;
            current_time  <= '0;
            heater_on     <= 1'b0;
            done_beep     <= 1'b0;
        end else begin
            case (state)
                S_OFF: begin
                    state <= S_SET_TEMP;
                    power <= 1'b1;
                end

                S_SET_TEMP: begin
                    if (enter_p) begin
                        state         <= S_SET_TIME;
                        tempInputDone <= 1'b1;
                        current_time  <= target_time;
                    end else if (up_p) begin
                        target_temp <= tgt_up;
                    end else if (down_p) begin
                        target_temp <= tgt_down;
                    end
                end

                S_SET_TIME: begin
                    if (enter_p) begin
                        // A zero cook time cannot be started.
                        if (target_time != '0) begin
                            state         <= S_PREHEAT;
                            timeInputDone <= 1'b1;
                            heater_on     <= 1'b1;
                        end
                    end else if (up_p) begin
                        target_time  <= tim_up;
                        current_time <= tim_up;
                    end else if (down_p) begin
                        target_time  <= tim_down;
                        current_time <= tim_down;
                    end
                end

                S_PREHEAT: begin
                    if (!below_target) begin
                        state     <= S_COOK;
                        heater_on <= 1'b0;
                    end else begin
                        heater_on <= 1'b1;
                    end
                end

                S_COOK: begin
                    if (tick && current_time <= 13'd1) begin
                        // Last second elapsed: finish on the same edge.
                        state        <= S_DONE;
                        current_time <= '0;
                        heater_on    <= 1'b0;
                        done_beep    <= 1'b1;
                    end else begin
                        heater_on <= below_target;
                        if (tick) begin
                            current_time <= current_time - 13'd1;
                        end
                    end
                end

                S_DONE: begin
                    if (enter_p) begin
                        state         <= S_SET_TEMP;
                        tempInputDone <= 1'b0;
                        timeInputDone <= 1'b0;
                        done_beep     <= 1'b0;
                    end
                end

                default: begin
                    state <= S_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oven_controller.sv
// tb_oven_controller
// Directed scenarios for the oven sequence plus a randomized key/power run
// compared cycle by cycle against a behavioural model of the oven.

`timescale 1ns/1ps

module tb_oven_controller;

    localparam int CPS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        power_sw = 1'b0;
    logic        key_up = 1'b0;
    logic        key_down = 1'b0;
    logic        key_enter = 1'b0;
    logic        power;
    logic        tempInputDone;
    logic        timeInputDone;
    logic [9:0]  current_temp;
    logic [9:0]  target_temp;
    logic [12:0] current_time;
    logic [12:0] target_time;
    logic        heater_on;
    logic        done_beep;

    int n_checks = 0;
    int n_fail   = 0;

    oven_controller #(.CLKS_PER_SEC(CPS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .power_sw      (power_sw),
        .key_up        (key_up),
        .key_down      (key_down),
        .key_enter     (key_enter),
        .power         (power),
        .tempInputDone (tempInputDone),
        .timeInputDone (timeInputDone),
        .current_temp  (current_temp),
        .target_temp   (target_temp),
        .current_time  (current_time),
        .target_time   (target_time),
        .heater_on     (heater_on),
        .done_beep     (done_beep)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural oven model: phases as small integers, values as plain ints.
    // ------------------------------------------------------------------
    localparam int PH_OFF = 0, PH_TEMP = 1, PH_TIME = 2, PH_PRE = 3, PH_COOK = 4, PH_DONE = 5;

    typedef struct {
        int phase;
        int cycles;
        int temp;
        int ttemp;
        int ctime;
        int ttime;
        bit heat;
        bit last_up;
        bit last_down;
        bit last_enter;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.phase = PH_OFF; r.cycles = 0; r.temp = 70; r.ttemp = 350;
        r.ctime = 0; r.ttime = 0; r.heat = 1'b0;
        r.last_up = 1'b0; r.last_down = 1'b0; r.last_enter = 1'b0;
        return r;
    endfunction

    function automatic model_t model_next(model_t c, bit sw, bit ku, bit kd, bit ke);
        model_t n;
        bit up, down, enter, sec;
        n = c;
        up    = ku && !c.last_up;
        down  = kd && !c.last_down;
        enter = ke && !c.last_enter;
        if (enter || (up && down)) begin
            up = 1'b0;
            down = 1'b0;
        end
        n.last_up = ku; n.last_down = kd; n.last_enter = ke;
        sec = ((c.cycles % CPS) == CPS - 1);
        n.cycles = c.cycles + 1;
        if (sec) n.temp = c.heat ? ((c.temp + 5 > 999) ? 999 : c.temp + 5)
                                 : ((c.temp - 2 < 70) ? 70 : c.temp - 2);
        if (!sw) begin
            n.phase = PH_OFF; n.ttemp = 350; n.ttime = 0; n.ctime = 0; n.heat = 1'b0;
            return n;
        end
        case (c.phase)
            PH_OFF: n.phase = PH_TEMP;
            PH_TEMP: begin
                if (enter) begin
                    n.phase = PH_TIME;
                    n.ctime = c.ttime;
                end else if (up) n.ttemp = (c.ttemp + 25 > 500) ? 500 : c.ttemp + 25;
                else if (down) n.ttemp = (c.ttemp - 25 < 100) ? 100 : c.ttemp - 25;
            end
            PH_TIME: begin
                if (enter) begin
                    if (c.ttime > 0) begin
                        n.phase = PH_PRE;
                        n.heat = 1'b1;
                    end
                end else begin
                    if (up) n.ttime = (c.ttime + 10 > 3599) ? 3599 : c.ttime + 10;
                    else if (down) n.ttime = (c.ttime - 10 < 0) ? 0 : c.ttime - 10;
                    n.ctime = n.ttime;
                end
            end
            PH_PRE: begin
                n.heat = 1'b1;
                if (c.temp >= c.ttemp) begin
                    n.phase = PH_COOK;
                    n.heat = 1'b0;
                end
            end
            PH_COOK: begin
                n.heat = (c.temp < c.ttemp);
                if (sec) begin
                    n.ctime = c.ctime - 1;
                    if (n.ctime <= 0) begin
                        n.ctime = 0;
                        n.phase = PH_DONE;
                        n.heat = 1'b0;
                    end
                end
            end
            PH_DONE: if (enter) n.phase = PH_TEMP;
            default: n.phase = PH_OFF;
        endcase
        return n;
    endfunction

    // Advance the model alongside the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, power_sw, key_up, key_down, key_enter);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive only; no checking).
    // ------------------------------------------------------------------
    task automatic press_up(input int n);
        repeat (n) begin
            key_up = 1'b1; @(negedge clk);
            key_up = 1'b0; @(negedge clk);
        end
    endtask

    task automatic press_down(input int n);
        repeat (n) begin
            key_down = 1'b1; @(negedge clk);
            key_down = 1'b0; @(negedge clk);
        end
    endtask

    task automatic press_enter(input int n);
        repeat (n) begin
            key_enter = 1'b1; @(negedge clk);
            key_enter = 1'b0; @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios.
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({power, tempInputDone, timeInputDone, heater_on, done_beep} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {power, tempInputDone, timeInputDone, heater_on, done_beep});
        end
        n_checks++;
        if (current_temp !== 10'd70 || target_temp !== 10'd350) begin
            n_fail++;
            $display("FAIL reset_temps: got cur=%0d tgt=%0d expected 70/350", current_temp, target_temp);
        end
        n_checks++;
        if (current_time !== 13'd0 || target_time !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_times: got cur=%0d tgt=%0d expected 0/0", current_time, target_time);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (power !== 1'b0) begin
            n_fail++;
            $display("FAIL off_hold: power got %b expected 0", power);
        end
    endtask

    task automatic test_set_temp();
        power_sw = 1'b1;
        @(negedge clk);
        n_checks++;
        if (power !== 1'b1 || target_temp !== 10'd350 || tempInputDone !== 1'b0 || timeInputDone !== 1'b0) begin
            n_fail++;
            $display("FAIL power_on: got pwr=%b tgt=%0d td=%b md=%b expected 1/350/0/0",
                     power, target_temp, tempInputDone, timeInputDone);
        end
        press_up(7);
        n_checks++;
        if (target_temp !== 10'd500) begin
            n_fail++;
            $display("FAIL temp_sat_max: got %0d expected 500", target_temp);
        end
        press_down(20);
        n_checks++;
        if (target_temp !== 10'd100) begin
            n_fail++;
            $display("FAIL temp_sat_min: got %0d expected 100", target_temp);
        end
    endtask

    task automatic test_key_rules();
        key_up = 1'b1;
        repeat (10) @(negedge clk);
        key_up = 1'b0;
        @(negedge clk);
        n_checks++;
        if (target_temp !== 10'd125) begin
            n_fail++;
            $display("FAIL key_hold: got %0d expected 125", target_temp);
        end
        key_up = 1'b1; key_down = 1'b1;
        @(negedge clk);
        key_up = 1'b0; key_down = 1'b0;
        @(negedge clk);
        n_checks++;
        if (target_temp !== 10'd125 || tempInputDone !== 1'b0) begin
            n_fail++;
            $display("FAIL up_down_cancel: got tgt=%0d td=%b expected 125/0", target_temp, tempInputDone);
        end
        press_down(1);
        key_enter = 1'b1; key_up = 1'b1;
        @(negedge clk);
        key_enter = 1'b0; key_up = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tempInputDone !== 1'b1 || target_temp !== 10'd100) begin
            n_fail++;
            $display("FAIL enter_wins: got td=%b tgt=%0d expected 1/100", tempInputDone, target_temp);
        end
    endtask

    task automatic test_set_time();
        press_enter(1);
        n_checks++;
        if (timeInputDone !== 1'b0 || tempInputDone !== 1'b1 || target_time !== 13'd0) begin
            n_fail++;
            $display("FAIL zero_time_enter: got md=%b td=%b t=%0d expected 0/1/0",
                     timeInputDone, tempInputDone, target_time);
        end
        press_up(3);
        n_checks++;
        if (target_time !== 13'd30 || current_time !== 13'd30) begin
            n_fail++;
            $display("FAIL time_set: got tgt=%0d cur=%0d expected 30/30", target_time, current_time);
        end
        key_enter = 1'b1;
        @(negedge clk);
        key_enter = 1'b0;
        n_checks++;
        if (timeInputDone !== 1'b1 || heater_on !== 1'b1 || current_temp !== 10'd70) begin
            n_fail++;
            $display("FAIL preheat_entry: got md=%b heat=%b temp=%0d expected 1/1/70",
                     timeInputDone, heater_on, current_temp);
        end
    endtask

    task automatic test_cook_cycle();
        int prev;
        int rises;
        int decs;
        bit ok;
        // Preheat: +5 per second from 70 to 100, then heater drops in COOK.
        prev = 70; rises = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (int'(current_temp) != prev) begin
                n_checks++;
                if (current_temp !== 10'(prev + 5)) begin
                    n_fail++;
                    $display("FAIL preheat_step: got %0d expected %0d", current_temp, prev + 5);
                end
                prev = int'(current_temp);
                rises++;
            end
            if (heater_on === 1'b0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || rises != 6 || current_temp !== 10'd100 || current_time !== 13'd30) begin
            n_fail++;
            $display("FAIL preheat_done: got ok=%b rises=%0d temp=%0d time=%0d expected 1/6/100/30",
                     ok, rises, current_temp, current_time);
        end
        // Cook: 30 one-second decrements, DONE on the last.
        prev = 30; decs = 0; ok = 1'b0;
        for (int i = 0; i < 30 * CPS + 40; i++) begin
            @(negedge clk);
            if (int'(current_time) != prev) begin
                n_checks++;
                if (current_time !== 13'(prev - 1)) begin
                    n_fail++;
                    $display("FAIL cook_step: got %0d expected %0d", current_time, prev - 1);
                end
                prev = int'(current_time);
                decs++;
            end
            if (done_beep === 1'b1) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || decs != 30 || current_time !== 13'd0 || heater_on !== 1'b0) begin
            n_fail++;
            $display("FAIL cook_done: got ok=%b decs=%0d time=%0d heat=%b expected 1/30/0/0",
                     ok, decs, current_time, heater_on);
        end
        n_checks++;
        if (current_temp !== 10'(m.temp)) begin
            n_fail++;
            $display("FAIL cook_temp: got %0d expected %0d", current_temp, m.temp);
        end
        // Done: cool 2 per second down to ambient.
        prev = int'(current_temp); ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (int'(current_temp) != prev) begin
                n_checks++;
                if (current_temp !== 10'((prev - 2 < 70) ? 70 : prev - 2)) begin
                    n_fail++;
                    $display("FAIL cool_step: got %0d expected %0d", current_temp,
                             (prev - 2 < 70) ? 70 : prev - 2);
                end
                prev = int'(current_temp);
            end
            if (current_temp === 10'd70) begin ok = 1'b1; break; end
        end
        repeat (2 * CPS) @(negedge clk);
        n_checks++;
        if (!ok || current_temp !== 10'd70 || done_beep !== 1'b1) begin
            n_fail++;
            $display("FAIL cool_floor: got ok=%b temp=%0d beep=%b expected 1/70/1", ok, current_temp, done_beep);
        end
    endtask

    task automatic test_power_off_mid_cook();
        bit ok;
        press_enter(1);
        n_checks++;
        if (tempInputDone !== 1'b0 || done_beep !== 1'b0 || target_temp !== 10'd100 || target_time !== 13'd30) begin
            n_fail++;
            $display("FAIL done_exit: got td=%b beep=%b tgt=%0d t=%0d expected 0/0/100/30",
                     tempInputDone, done_beep, target_temp, target_time);
        end
        press_enter(1);
        n_checks++;
        if (current_time !== 13'd30 || tempInputDone !== 1'b1) begin
            n_fail++;
            $display("FAIL time_mirror: got cur=%0d td=%b expected 30/1", current_time, tempInputDone);
        end
        press_enter(1);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (current_time < 13'd30) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reach_cook: got time=%0d expected below 30 within budget", current_time);
        end
        power_sw = 1'b0;
        @(negedge clk);
        n_checks++;
        if (power !== 1'b0 || current_time !== 13'd0 || target_time !== 13'd0 ||
            target_temp !== 10'd350 || heater_on !== 1'b0) begin
            n_fail++;
            $display("FAIL power_drop: got pwr=%b cur=%0d tgt_t=%0d tgt=%0d heat=%b expected 0/0/0/350/0",
                     power, current_time, target_time, target_temp, heater_on);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        power_sw = 1'b1;
        @(negedge clk);
        press_down(10);
        press_enter(1);
        press_up(1);
        press_enter(1);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (current_time < 13'd10) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reach_cook2: got time=%0d expected below 10 within budget", current_time);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({power, tempInputDone, timeInputDone, heater_on, done_beep} !== 5'b0 ||
            current_temp !== 10'd70 || target_temp !== 10'd350 ||
            current_time !== 13'd0 || target_time !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset: got flags=%b temp=%0d tgt=%0d cur_t=%0d tgt_t=%0d expected 00000/70/350/0/0",
                     {power, tempInputDone, timeInputDone, heater_on, done_beep},
                     current_temp, target_temp, current_time, target_time);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [50:0] got;
        logic [50:0] exp;
        for (int i = 0; i < 3000; i++) begin
            got = {power, tempInputDone, timeInputDone, heater_on, done_beep,
                   current_temp, target_temp, current_time, target_time};
            exp = {m.phase != PH_OFF, m.phase >= PH_TIME, m.phase >= PH_PRE, m.heat, m.phase == PH_DONE,
                   10'(m.temp), 10'(m.ttemp), 13'(m.ctime), 13'(m.ttime)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: dut=%h model=%h", i, got, exp);
            end
            power_sw  = ($urandom_range(0, 299) != 0);
            key_up    = ($urandom_range(0, 3) == 0);
            key_down  = ($urandom_range(0, 4) == 0);
            key_enter = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
    endtask

    initial begin
        test_reset();
        test_set_temp();
        test_key_rules();
        test_set_time();
        test_cook_cycle();
        test_power_off_mid_cook();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
